// File: rtl/devil_campaign_sequencer.sv
// Steps a devil_in_fpga attack engine through a table of (control, delay) entries, looping a programmed count.
// Optional macro DEVIL_SEQ_LATENCY_EN: o_last_latency reports WAIT_END cycles of the last completed step.
module devil_campaign_sequencer #(
    parameter  int C_S_AXI_DATA_WIDTH = 32,
    parameter  int NUM_ENTRIES        = 8,
    parameter  int TIMEOUT_W          = 24,
    localparam int IDX_W              = $clog2(NUM_ENTRIES),
    localparam int DW                 = C_S_AXI_DATA_WIDTH
) (
    input  logic                 ace_aclk,
    input  logic                 ace_aresetn,
    input  logic                 i_cfg_we,
    input  logic [IDX_W-1:0]     i_cfg_idx,
    input  logic [DW-1:0]        i_cfg_ctrl,
    input  logic [DW-1:0]        i_cfg_delay,
    input  logic [IDX_W:0]       i_num_steps,
    input  logic [7:0]           i_loops,
    input  logic [15:0]          i_gap,
    input  logic [TIMEOUT_W-1:0] i_timeout,
    input  logic                 i_start,
    input  logic                 i_abort,
    input  logic                 i_devil_end,
    output logic [DW-1:0]        o_control_reg,
    output logic [DW-1:0]        o_delay_reg,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_timeout_err,
    output logic [IDX_W-1:0]     o_step_idx,
    output logic [7:0]           o_loop_cnt,
    output logic [DW-1:0]        o_last_latency
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_ARM, S_WAIT_END, S_RELEASE, S_GAP, S_NEXT, S_DONE
    } state_t;

    localparam logic [IDX_W:0]     L_NUM = (IDX_W+1)'(NUM_ENTRIES);
    localparam logic [IDX_W:0]     L_ONE = (IDX_W+1)'(1);
    localparam logic [TIMEOUT_W-1:0] L_T1 = TIMEOUT_W'(1);

    state_t               r_state, w_next;
    logic [DW-1:0]        r_tab_ctrl  [NUM_ENTRIES];
    logic [DW-1:0]        r_tab_delay [NUM_ENTRIES];
    logic [DW-1:0]        r_control, r_delay, r_delay_lat;
    logic                 r_en_lat;
    logic [IDX_W-1:0]     r_step;
    logic [7:0]           r_loops, r_loop_term, r_loop_cnt;
    logic [15:0]          r_gap_cnt;
    logic [TIMEOUT_W-1:0] r_timeout, r_timer;
    logic                 r_abort, r_timeout_err;
    logic                 w_busy, w_abort, w_tmo_hit, w_wrap, w_end_loops;
    logic [IDX_W:0]       w_num_eff, w_last_full;

    // Start/done protocol: i_start is a one-cycle request honoured only in IDLE;
    // o_done pulses for exactly one cycle when the campaign finishes or is aborted.
    always_comb begin
        if (i_num_steps == '0)       w_num_eff = L_ONE;
        else if (i_num_steps > L_NUM) w_num_eff = L_NUM;
        else                          w_num_eff = i_num_steps;
    end

    assign w_last_full = w_num_eff - L_ONE;
    assign w_wrap      = ({1'b0, r_step} == w_last_full);
    assign w_end_loops = (r_loops != 8'd0) && ((r_loop_term + 8'd1) == r_loops);
    assign w_tmo_hit   = (r_timeout != '0) && (r_timer == r_timeout - L_T1);
    assign w_busy      = (r_state != S_IDLE) && (r_state != S_DONE);
    assign w_abort     = w_busy && (i_abort || r_abort);

    // Table has no reset; contents are undefined until written.
    always_ff @(posedge ace_aclk) begin
        if (i_cfg_we && !w_busy) begin
            r_tab_ctrl[i_cfg_idx]  <= i_cfg_ctrl;
            r_tab_delay[i_cfg_idx] <= i_cfg_delay;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:     if (i_start) w_next = S_LOAD;
            S_LOAD:     w_next = w_abort ? S_RELEASE : S_ARM;
            S_ARM:      w_next = w_abort ? S_RELEASE : S_WAIT_END;
            S_WAIT_END: if (w_abort || i_devil_end || w_tmo_hit) w_next = S_RELEASE;
            S_RELEASE: begin
                if (!i_devil_end) begin
                    if (w_abort)            w_next = S_DONE;
                    else if (i_gap == 16'd0) w_next = S_NEXT;
                    else                    w_next = S_GAP;
                end
            end
            S_GAP: begin
                if (w_abort)                  w_next = S_RELEASE;
                else if (r_gap_cnt == 16'd1) w_next = S_NEXT;
            end
            S_NEXT: begin
                if (w_abort)                   w_next = S_RELEASE;
                else if (w_wrap && w_end_loops) w_next = S_DONE;
                else                           w_next = S_LOAD;
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge ace_aclk or negedge ace_aresetn) begin
        if (!ace_aresetn) begin
            r_state       <= S_IDLE;
            r_control     <= '0;
            r_delay       <= '0;
            r_delay_lat   <= '0;
            r_en_lat      <= 1'b0;
            r_step        <= '0;
            r_loops       <= '0;
            r_loop_term   <= '0;
            r_loop_cnt    <= '0;
            r_gap_cnt     <= '0;
            r_timeout     <= '0;
            r_timer       <= '0;
            r_abort       <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_busy && i_abort)     r_abort <= 1'b1;
            else if (r_state == S_DONE) r_abort <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_step        <= '0;
                        r_loop_term   <= '0;
                        r_loop_cnt    <= '0;
                        r_loops       <= i_loops;
                        r_timeout_err <= 1'b0;
                    end
                end
                S_LOAD: begin
                    r_en_lat    <= r_tab_ctrl[r_step][0];
                    r_delay_lat <= r_tab_delay[r_step];
                    r_timeout   <= i_timeout;
                end
                S_ARM: begin
                    r_timer <= '0;
                    if (!w_abort) r_delay <= r_delay_lat;
                end
                S_WAIT_END: begin
                    r_timer <= r_timer + L_T1;
                    if (!w_abort && !i_devil_end && w_tmo_hit) r_timeout_err <= 1'b1;
                end
                S_RELEASE: if (!i_devil_end) r_gap_cnt <= i_gap;
                S_GAP:     r_gap_cnt <= r_gap_cnt - 16'd1;
                S_NEXT: begin
                    if (!w_abort) begin
                        if (w_wrap) begin
                            r_step      <= '0;
                            r_loop_term <= r_loop_term + 8'd1;
                            if (r_loop_cnt != 8'hFF) r_loop_cnt <= r_loop_cnt + 8'd1;
                        end else begin
                            r_step <= r_step + IDX_W'(1);
                        end
                    end
                end
                default: ;
            endcase

            // Enable bit only reaches the engine one cycle after the rest of the control word.
            case (w_next)
                S_ARM:      r_control <= {r_tab_ctrl[r_step][DW-1:1], 1'b0};
                S_WAIT_END: r_control <= r_control | {{(DW-1){1'b0}}, r_en_lat};
                default:    r_control <= '0;
            endcase
        end
    end

`ifdef DEVIL_SEQ_LATENCY_EN
    logic [DW-1:0] r_lat_cnt, r_last_lat;

    always_ff @(posedge ace_aclk or negedge ace_aresetn) begin
        if (!ace_aresetn) begin
            r_lat_cnt  <= '0;
            r_last_lat <= '0;
        end else begin
            if (r_state == S_ARM)
                r_lat_cnt <= '0;
            else if (r_state == S_WAIT_END && r_lat_cnt != '1)
                r_lat_cnt <= r_lat_cnt + DW'(1);
            if (r_state == S_WAIT_END && !w_abort && i_devil_end)
                r_last_lat <= (r_lat_cnt == '1) ? r_lat_cnt : r_lat_cnt + DW'(1);
        end
    end

    assign o_last_latency = r_last_lat;
`else
    assign o_last_latency = '0;
`endif

    assign o_control_reg = r_control;
    assign o_delay_reg   = r_delay;
    assign o_busy        = w_busy;
    assign o_done        = (r_state == S_DONE);
    assign o_timeout_err = r_timeout_err;
    assign o_step_idx    = r_step;
    assign o_loop_cnt    = r_loop_cnt;

endmodule

// File: tb/tb_devil_campaign_sequencer.sv
// Directed bench for devil_campaign_sequencer with a simple engine model that raises end after N enabled cycles.
`timescale 1ns/1ps
module tb_devil_campaign_sequencer;

    localparam logic [31:0] E0 = 32'h0001_0001;
    localparam logic [31:0] E1 = 32'h0002_0023;
    localparam logic [31:0] D0 = 32'h0000_0064;
    localparam logic [31:0] D1 = 32'h0000_00C8;
    localparam logic [31:0] CA = 32'h0000_0011;
    localparam logic [31:0] CB = 32'h0000_0F01;
    localparam logic [31:0] CC = 32'h0000_0A05;
`ifdef DEVIL_SEQ_LATENCY_EN
    localparam logic [31:0] EXP_LAT = 32'd10;
`else
    localparam logic [31:0] EXP_LAT = 32'd0;
`endif

    logic        ace_aclk = 1'b0;
    logic        ace_aresetn = 1'b0;
    logic        i_cfg_we = 1'b0;
    logic [2:0]  i_cfg_idx = '0;
    logic [31:0] i_cfg_ctrl = '0;
    logic [31:0] i_cfg_delay = '0;
    logic [3:0]  i_num_steps = '0;
    logic [7:0]  i_loops = '0;
    logic [15:0] i_gap = '0;
    logic [23:0] i_timeout = '0;
    logic        i_start = 1'b0;
    logic        i_abort = 1'b0;
    logic        i_devil_end = 1'b0;
    logic [31:0] o_control_reg, o_delay_reg, o_last_latency;
    logic        o_busy, o_done, o_timeout_err;
    logic [2:0]  o_step_idx;
    logic [7:0]  o_loop_cnt;

    int n_checks = 0;
    int n_pass = 0;
    int end_after = 0;
    int eng_hold = 0;
    int en_cnt = 0;
    int hold_left = 0;

    logic [31:0] tr_ctrl[$];
    logic [31:0] tr_delay[$];
    logic        tr_done[$];
    logic        tr_busy[$];
    logic        tr_err[$];
    logic [2:0]  tr_step[$];
    logic [7:0]  tr_loop[$];

    devil_campaign_sequencer dut (
        .ace_aclk      (ace_aclk),
        .ace_aresetn   (ace_aresetn),
        .i_cfg_we      (i_cfg_we),
        .i_cfg_idx     (i_cfg_idx),
        .i_cfg_ctrl    (i_cfg_ctrl),
        .i_cfg_delay   (i_cfg_delay),
        .i_num_steps   (i_num_steps),
        .i_loops       (i_loops),
        .i_gap         (i_gap),
        .i_timeout     (i_timeout),
        .i_start       (i_start),
        .i_abort       (i_abort),
        .i_devil_end   (i_devil_end),
        .o_control_reg (o_control_reg),
        .o_delay_reg   (o_delay_reg),
        .o_busy        (o_busy),
        .o_done        (o_done),
        .o_timeout_err (o_timeout_err),
        .o_step_idx    (o_step_idx),
        .o_loop_cnt    (o_loop_cnt),
        .o_last_latency(o_last_latency)
    );

    // Clock / reset
    always #5 ace_aclk = ~ace_aclk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // Engine model: end rises after end_after enabled cycles, held eng_hold cycles after enable drops.
    always @(negedge ace_aclk or negedge ace_aresetn) begin
        if (!ace_aresetn) begin
            en_cnt = 0;
            hold_left = 0;
            i_devil_end = 1'b0;
        end else if (o_control_reg[0]) begin
            en_cnt++;
            if (end_after != 0 && en_cnt >= end_after) begin
                i_devil_end = 1'b1;
                hold_left = eng_hold;
            end
        end else begin
            en_cnt = 0;
            if (hold_left > 0) hold_left--;
            if (hold_left == 0) i_devil_end = 1'b0;
        end
    end

    // Driver tasks
    task automatic write_entry(input logic [2:0] idx, input logic [31:0] c, input logic [31:0] d);
        @(negedge ace_aclk);
        i_cfg_we = 1'b1; i_cfg_idx = idx; i_cfg_ctrl = c; i_cfg_delay = d;
        @(negedge ace_aclk);
        i_cfg_we = 1'b0;
    endtask

    task automatic clear_trace();
        tr_ctrl.delete(); tr_delay.delete(); tr_done.delete(); tr_busy.delete();
        tr_err.delete(); tr_step.delete(); tr_loop.delete();
    endtask

    // Sample index 0 is the negedge right after the edge that accepted i_start.
    task automatic do_start();
        @(negedge ace_aclk);
        i_start = 1'b1;
        @(negedge ace_aclk);
        i_start = 1'b0;
        clear_trace();
    endtask

    task automatic capture(input int n);
        for (int i = 0; i < n; i++) begin
            tr_ctrl.push_back(o_control_reg);
            tr_delay.push_back(o_delay_reg);
            tr_done.push_back(o_done);
            tr_busy.push_back(o_busy);
            tr_err.push_back(o_timeout_err);
            tr_step.push_back(o_step_idx);
            tr_loop.push_back(o_loop_cnt);
            @(negedge ace_aclk);
        end
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (o_busy !== 1'b0 && k < 300) begin
            @(negedge ace_aclk);
            k++;
        end
        n_checks++; if (o_busy !== 1'b0) $display("FAIL wait_idle: busy=%b required 0 after %0d cycles", o_busy, k); else n_pass++;
        repeat (2) @(negedge ace_aclk);
    endtask

    // Scenarios
    task automatic test_reset();
        repeat (3) @(negedge ace_aclk);
        n_checks++; if (o_control_reg !== 32'h0) $display("FAIL rst_ctrl: got %h required 0", o_control_reg); else n_pass++;
        n_checks++; if (o_delay_reg !== 32'h0) $display("FAIL rst_delay: got %h required 0", o_delay_reg); else n_pass++;
        n_checks++; if ({o_busy, o_done, o_timeout_err} !== 3'b000) $display("FAIL rst_flags: got %b required 000", {o_busy, o_done, o_timeout_err}); else n_pass++;
        n_checks++; if ({o_step_idx, o_loop_cnt} !== 11'h0) $display("FAIL rst_cnt: got %h required 0", {o_step_idx, o_loop_cnt}); else n_pass++;
        n_checks++; if (o_last_latency !== 32'h0) $display("FAIL rst_lat: got %h required 0", o_last_latency); else n_pass++;
        ace_aresetn = 1'b1;
        @(negedge ace_aclk);
        n_checks++; if (o_busy !== 1'b0) $display("FAIL rst_idle_busy: got %b required 0", o_busy); else n_pass++;
    endtask

    task automatic test_basic_campaign();
        int np;
        write_entry(3'd0, E0, D0);
        write_entry(3'd1, E1, D1);
        i_num_steps = 4'd2; i_loops = 8'd1; i_gap = 16'd4; i_timeout = '0;
        end_after = 10; eng_hold = 0;
        do_start();
        capture(40);
        np = 0;
        foreach (tr_done[i]) if (tr_done[i] === 1'b1) np++;
        n_checks++; if (tr_busy[0] !== 1'b1) $display("FAIL t1_busy0: got %b required 1", tr_busy[0]); else n_pass++;
        n_checks++; if (tr_ctrl[0] !== 32'h0) $display("FAIL t1_ctrl_load: got %h required 0", tr_ctrl[0]); else n_pass++;
        n_checks++; if (tr_ctrl[1] !== 32'h0001_0000) $display("FAIL t1_ctrl_arm: got %h required 00010000", tr_ctrl[1]); else n_pass++;
        n_checks++; if (tr_ctrl[2] !== E0) $display("FAIL t1_ctrl_en0: got %h required %h", tr_ctrl[2], E0); else n_pass++;
        n_checks++; if (tr_delay[1] !== 32'h0 || tr_delay[2] !== D0) $display("FAIL t1_delay0: got %h/%h required 0/%h", tr_delay[1], tr_delay[2], D0); else n_pass++;
        n_checks++; if (tr_ctrl[11] !== E0) $display("FAIL t1_ctrl_hold0: got %h required %h", tr_ctrl[11], E0); else n_pass++;
        n_checks++; if (tr_ctrl[12] !== 32'h0) $display("FAIL t1_ctrl_rel0: got %h required 0", tr_ctrl[12]); else n_pass++;
        n_checks++; if (tr_ctrl[19] !== 32'h0002_0022) $display("FAIL t1_ctrl_arm1: got %h required 00020022", tr_ctrl[19]); else n_pass++;
        n_checks++; if (tr_ctrl[20] !== E1 || tr_delay[20] !== D1) $display("FAIL t1_ctrl_en1: got %h/%h required %h/%h", tr_ctrl[20], tr_delay[20], E1, D1); else n_pass++;
        n_checks++; if (tr_step[20] !== 3'd1) $display("FAIL t1_step1: got %0d required 1", tr_step[20]); else n_pass++;
        n_checks++; if (tr_ctrl[30] !== 32'h0) $display("FAIL t1_ctrl_rel1: got %h required 0", tr_ctrl[30]); else n_pass++;
        n_checks++; if (tr_done[35] !== 1'b0 || tr_done[36] !== 1'b1) $display("FAIL t1_done_time: got %b%b required 01", tr_done[35], tr_done[36]); else n_pass++;
        n_checks++; if (np != 1) $display("FAIL t1_done_pulses: got %0d required 1", np); else n_pass++;
        n_checks++; if (tr_busy[35] !== 1'b1 || tr_busy[36] !== 1'b0) $display("FAIL t1_busy_end: got %b%b required 10", tr_busy[35], tr_busy[36]); else n_pass++;
        n_checks++; if (tr_loop[36] !== 8'd1 || tr_step[36] !== 3'd0) $display("FAIL t1_loop_cnt: got %0d/%0d required 1/0", tr_loop[36], tr_step[36]); else n_pass++;
        n_checks++; if (o_last_latency !== EXP_LAT) $display("FAIL t1_latency: got %0d required %0d", o_last_latency, EXP_LAT); else n_pass++;
        wait_idle();
    endtask

    task automatic test_timeout();
        i_num_steps = 4'd2; i_loops = 8'd1; i_gap = 16'd0; i_timeout = 24'd20;
        end_after = 0; eng_hold = 0;
        do_start();
        capture(50);
        n_checks++; if (tr_ctrl[21] !== E0) $display("FAIL t2_ctrl_wait: got %h required %h", tr_ctrl[21], E0); else n_pass++;
        n_checks++; if (tr_err[21] !== 1'b0 || tr_err[22] !== 1'b1) $display("FAIL t2_err_time: got %b%b required 01", tr_err[21], tr_err[22]); else n_pass++;
        n_checks++; if (tr_ctrl[22] !== 32'h0) $display("FAIL t2_ctrl_rel: got %h required 0", tr_ctrl[22]); else n_pass++;
        n_checks++; if (tr_ctrl[25] !== 32'h0002_0022 || tr_ctrl[26] !== E1) $display("FAIL t2_next_step: got %h/%h required 00020022/%h", tr_ctrl[25], tr_ctrl[26], E1); else n_pass++;
        n_checks++; if (tr_done[47] !== 1'b0 || tr_done[48] !== 1'b1) $display("FAIL t2_done_time: got %b%b required 01", tr_done[47], tr_done[48]); else n_pass++;
        n_checks++; if (tr_err[48] !== 1'b1) $display("FAIL t2_err_sticky: got %b required 1", tr_err[48]); else n_pass++;
        wait_idle();
        i_timeout = '0;
    endtask

    task automatic test_release_hold();
        i_num_steps = 4'd1; i_loops = 8'd1; i_gap = 16'd2;
        end_after = 10; eng_hold = 5;
        do_start();
        capture(24);
        n_checks++; if (tr_err[0] !== 1'b0) $display("FAIL t3_err_clear: got %b required 0", tr_err[0]); else n_pass++;
        n_checks++; if (tr_ctrl[11] !== E0 || tr_ctrl[12] !== 32'h0) $display("FAIL t3_ctrl_drop: got %h/%h required %h/0", tr_ctrl[11], tr_ctrl[12], E0); else n_pass++;
        n_checks++; if (tr_busy[19] !== 1'b1 || tr_done[19] !== 1'b0) $display("FAIL t3_pre_done: got busy %b done %b required 1 0", tr_busy[19], tr_done[19]); else n_pass++;
        n_checks++; if (tr_done[20] !== 1'b1) $display("FAIL t3_done_time: got %b required 1", tr_done[20]); else n_pass++;
        wait_idle();
        eng_hold = 0;
    endtask

    task automatic test_abort();
        i_num_steps = 4'd2; i_loops = 8'd0; i_gap = 16'd4;
        end_after = 10; eng_hold = 0;
        do_start();
        capture(50);
        i_abort = 1'b1;
        capture(1);
        i_abort = 1'b0;
        capture(5);
        n_checks++; if (tr_ctrl[38] !== E0 || tr_loop[38] !== 8'd1) $display("FAIL t4_third_step: got %h/%0d required %h/1", tr_ctrl[38], tr_loop[38], E0); else n_pass++;
        n_checks++; if (tr_ctrl[50] !== 32'h0 || tr_step[50] !== 3'd0) $display("FAIL t4_in_gap: got %h/%0d required 0/0", tr_ctrl[50], tr_step[50]); else n_pass++;
        n_checks++; if (tr_busy[51] !== 1'b1 || tr_done[51] !== 1'b0) $display("FAIL t4_release: got busy %b done %b required 1 0", tr_busy[51], tr_done[51]); else n_pass++;
        n_checks++; if (tr_done[52] !== 1'b1 || tr_busy[52] !== 1'b0) $display("FAIL t4_done: got done %b busy %b required 1 0", tr_done[52], tr_busy[52]); else n_pass++;
        n_checks++; if (tr_done[53] !== 1'b0 || tr_busy[53] !== 1'b0 || tr_ctrl[53] !== 32'h0) $display("FAIL t4_idle: got done %b busy %b ctrl %h required 0 0 0", tr_done[53], tr_busy[53], tr_ctrl[53]); else n_pass++;
        wait_idle();
    endtask

    task automatic test_cfg_write();
        write_entry(3'd0, CA, D0);
        i_num_steps = 4'd1; i_loops = 8'd1; i_gap = 16'd0;
        end_after = 10; eng_hold = 0;
        do_start();
        capture(3);
        write_entry(3'd0, CB, D1);
        wait_idle();
        do_start();
        capture(3);
        n_checks++; if (tr_ctrl[2] !== CA || tr_delay[2] !== D0) $display("FAIL t5_busy_write: got %h/%h required %h/%h", tr_ctrl[2], tr_delay[2], CA, D0); else n_pass++;
        wait_idle();
        @(negedge ace_aclk);
        i_start = 1'b1; i_cfg_we = 1'b1; i_cfg_idx = 3'd0; i_cfg_ctrl = CC; i_cfg_delay = D1;
        @(negedge ace_aclk);
        i_start = 1'b0; i_cfg_we = 1'b0;
        clear_trace();
        capture(3);
        n_checks++; if (tr_ctrl[1] !== 32'h0000_0A04) $display("FAIL t5_same_cycle_arm: got %h required 00000a04", tr_ctrl[1]); else n_pass++;
        n_checks++; if (tr_ctrl[2] !== CC || tr_delay[2] !== D1) $display("FAIL t5_same_cycle_en: got %h/%h required %h/%h", tr_ctrl[2], tr_delay[2], CC, D1); else n_pass++;
        wait_idle();
    endtask

    task automatic test_async_reset();
        write_entry(3'd0, E0, D0);
        i_num_steps = 4'd1; i_loops = 8'd1; i_gap = 16'd0;
        end_after = 10; eng_hold = 0;
        do_start();
        capture(6);
        n_checks++; if (o_control_reg !== E0) $display("FAIL t6_pre_reset: got %h required %h", o_control_reg, E0); else n_pass++;
        ace_aresetn = 1'b0;
        #1;
        n_checks++; if (o_control_reg !== 32'h0) $display("FAIL t6_async_ctrl: got %h required 0", o_control_reg); else n_pass++;
        n_checks++; if (o_busy !== 1'b0) $display("FAIL t6_async_busy: got %b required 0", o_busy); else n_pass++;
        n_checks++; if (o_last_latency !== 32'h0 || o_delay_reg !== 32'h0) $display("FAIL t6_async_regs: got %h/%h required 0/0", o_last_latency, o_delay_reg); else n_pass++;
        @(negedge ace_aclk);
        ace_aresetn = 1'b1;
        do_start();
        capture(3);
        n_checks++; if (tr_ctrl[2] !== E0) $display("FAIL t6_recover: got %h required %h", tr_ctrl[2], E0); else n_pass++;
        wait_idle();
    endtask

    initial begin
        test_reset();
        test_basic_campaign();
        test_timeout();
        test_release_hold();
        test_abort();
        test_cfg_write();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
